uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's UART_Tx on the BASYS3.
- Deserialises an asynchronous 8N1/8E1/8O1-style frame from the RX pin into a parallel word and flags parity and stop errors.
- Sits between the board RX pin and user logic.
- Frame format matches UART_Tx exactly: start bit, P_data_width data bits LSB first, optional parity bit, one stop bit.

Parameters:
- CLK_freq, 100_000_000, master clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate. CLK_Ticks = CLK_freq/BAUD_RATE, integer-truncated; elaboration fails if CLK_Ticks < 8.
- P_data_width, 8, data bits per frame.
- data_size_address, $clog2(P_data_width), width of the data-bit index counter.

Ports:
- CLK  input  1  master clock; all logic is on its rising edge.
- RST  input  1  reset, synchronous, active-high.
- RX_IN  input  1  asynchronous serial line; idles high.
- PAR_EN  input  1  1 = a parity bit is expected after the data bits.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_data  output  P_data_width  last correctly received word.
- DATA_VALID  output  1  one-cycle pulse when P_data is updated.
- PAR_ERR  output  1  one-cycle pulse on parity mismatch.
- STP_ERR  output  1  one-cycle pulse when the stop bit is sampled low.
- Busy  output  1  high from start-bit detection to the end of the frame.

Behaviour:
- Input synchroniser: RX_IN passes through a 2-FF synchroniser (rx_s) before any use. The synchroniser flops reset to 1.
- Reset values: P_data = 0, DATA_VALID = 0, PAR_ERR = 0, STP_ERR = 0, Busy = 0, FSM = IDLE, counters = 0.
- RST asserted mid-frame aborts the frame immediately. No pulses are emitted. P_data keeps its reset value of 0.
- Tick counter: counts 0..CLK_Ticks-1 within each bit. The sample point is count == CLK_Ticks/2 - 1.
- State IDLE:
  - Waits for rx_s == 0 with armed == 1. On that condition: go to START, clear the tick counter, Busy = 1.
  - Latch PAR_EN and PAR_TYP into internal copies. The input ports may change mid-frame without effect.
  - armed is set while rx_s == 1 in IDLE.
- State START:
  - At the sample point, rx_s == 1 is a glitch: return to IDLE, Busy = 0, no pulses.
  - At the sample point, rx_s == 0: realign so later samples fall mid-bit, then go to DATA with bit index 0.
- State DATA:
  - One sample per CLK_Ticks. The sample is shifted in LSB first.
  - After bit P_data_width-1: go to PARITY if the latched PAR_EN is 1, else STOP.
- State PARITY:
  - Sample the parity bit.
  - Mismatch when XOR(data bits, parity bit) != latched PAR_TYP. On mismatch set an internal par_bad flag.
  - Then go to STOP.
- State STOP:
  - Sample the stop bit, then go to IDLE and drop Busy in the same cycle.
  - The next cycle emits exactly one outcome, as a single-cycle pulse:
    - stop bit 0: STP_ERR only.
    - stop bit 1 and par_bad: PAR_ERR only.
    - otherwise: P_data is loaded and DATA_VALID pulses.
  - Clear par_bad.
  - After a stop bit of 0, armed is cleared. A line held low (break) therefore yields one STP_ERR and no further frames until rx_s returns high.
- P_data changes only together with a DATA_VALID pulse and holds between frames.
- Back-to-back frames: a new start bit is accepted on the first cycle after the STOP sample in which rx_s == 0 and armed == 1. No idle gap is required.
- Latency: the DATA_VALID pulse occurs 2 (synchroniser) + (1.5 + P_data_width + PAR_EN) × CLK_Ticks + 1 cycles after the RX_IN falling edge, ±1 cycle.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every bit value, start bit included, is the 2-of-3 majority of rx_s taken at sample point -1, 0 and +1. A single-cycle glitch at the sample point is rejected.
- Undefined: a single rx_s sample at the sample point. Everything else is identical, including timing.

Test Plan:
- CLK_freq = 16_000_000, BAUD_RATE = 1_000_000 (16 ticks/bit), PAR_EN = 0. Drive 0xA5 LSB first with a stop bit of 1 → one DATA_VALID pulse, P_data = 0xA5, PAR_ERR = 0, STP_ERR = 0, Busy high for ~10 bit times.
- PAR_EN = 1, PAR_TYP = 0. Send 0x37 with parity 1 → DATA_VALID, P_data = 0x37. Repeat with parity 0 → PAR_ERR pulse, no DATA_VALID, P_data stays 0x37.
- PAR_EN = 1, PAR_TYP = 1. Send 0x00 with parity 1 → DATA_VALID, P_data = 0x00.
- Send 0x5A with the stop bit forced to 0, then hold the line low for 3 frames → exactly one STP_ERR, no DATA_VALID. Release high, then send 0x81 → DATA_VALID, P_data = 0x81.
- 4-cycle low glitch on an idle line → returns to IDLE, Busy pulses briefly, no output pulses. Back-to-back frames 0x01, 0xFE, 0x7F → three DATA_VALID pulses in order.
- Assert RST at bit 4 of frame 0xC3 → all outputs 0 the next cycle, no pulses. Then send 0x3C → DATA_VALID, P_data = 0x3C.
- With UART_RX_MAJORITY_EN defined: a 1-cycle inverted glitch at the sample point of bit 2 of 0x55 → P_data = 0x55.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: start bit, P_data_width data bits LSB first, optional parity, one stop bit.
// Optional 2-of-3 majority bit sampling is enabled with `define UART_RX_MAJORITY_EN.
module uart_rx #(
    parameter int unsigned CLK_freq          = 100_000_000,
    parameter int unsigned BAUD_RATE         = 9600,
    parameter int unsigned P_data_width      = 8,
    parameter int unsigned data_size_address = $clog2(P_data_width)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    RX_IN,
    input  logic                    PAR_EN,
    input  logic                    PAR_TYP,
    output logic [P_data_width-1:0] P_data,
    output logic                    DATA_VALID,
    output logic                    PAR_ERR,
    output logic                    STP_ERR,
    output logic                    Busy
);

    localparam int unsigned CLK_TICKS = CLK_freq / BAUD_RATE;
    localparam int unsigned TICK_W    = $clog2(CLK_TICKS);
    localparam int unsigned SAMPLE    = CLK_TICKS / 2 - 1;
    // Bit decisions are taken one tick after the sample point so the majority
    // vote can see the sample after it; the plain build uses the same timing.
    localparam int unsigned DECIDE    = SAMPLE + 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned HIST_W    = 2;
`else
    localparam int unsigned HIST_W    = 1;
`endif

    generate
        if (CLK_TICKS < 8) begin : g_tick_check
            $error("uart_rx: CLK_freq/BAUD_RATE must be at least 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                       state_q, state_d;
    logic                         rx_meta_q, rx_meta_d;
    logic                         rx_s_q, rx_s_d;
    logic [HIST_W-1:0]            hist_q, hist_d;
    logic [TICK_W-1:0]            tick_q, tick_d;
    logic [data_size_address-1:0] idx_q, idx_d;
    logic [P_data_width-1:0]      shift_q, shift_d;
    logic [P_data_width:0]        shift_cat_c;
    logic                         par_en_q, par_en_d;
    logic                         par_typ_q, par_typ_d;
    logic                         par_bad_q, par_bad_d;
    logic                         armed_q, armed_d;
    logic                         busy_q, busy_d;
    logic [P_data_width-1:0]      p_data_q, p_data_d;
    logic                         dv_q, dv_d;
    logic                         perr_q, perr_d;
    logic                         serr_q, serr_d;
    logic                         bit_c;
    logic                         decide_c;

`ifdef UART_RX_MAJORITY_EN
    assign bit_c = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign bit_c = hist_q[0];
`endif
    assign decide_c    = (tick_q == TICK_W'(DECIDE));
    assign shift_cat_c = {bit_c, shift_q};

    // Next-state and output logic
    always_comb begin
        rx_meta_d = RX_IN;
        rx_s_d    = rx_meta_q;
`ifdef UART_RX_MAJORITY_EN
        hist_d    = {hist_q[0], rx_s_q};
`else
        hist_d    = rx_s_q;
`endif
        state_d   = state_q;
        tick_d    = tick_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_bad_d = par_bad_q;
        armed_d   = armed_q;
        busy_d    = busy_q;
        p_data_d  = p_data_q;
        dv_d      = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;

        if (state_q != ST_IDLE) begin
            tick_d = (tick_q == TICK_W'(CLK_TICKS - 1)) ? '0 : tick_q + TICK_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d   = ST_START;
                    busy_d    = 1'b1;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end
            end
            ST_START: begin
                if (decide_c) begin
                    if (bit_c) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        // Free-running tick keeps later decisions mid-bit
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (decide_c) begin
                    shift_d = shift_cat_c[P_data_width:1];
                    if (idx_q == data_size_address'(P_data_width - 1)) begin
                        idx_d   = '0;
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + data_size_address'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (decide_c) begin
                    par_bad_d = ((^shift_q) ^ bit_c) != par_typ_q;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide_c) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    armed_d   = bit_c;
                    par_bad_d = 1'b0;
                    if (!bit_c) begin
                        serr_d = 1'b1;
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
                    end else begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            hist_q    <= '1;
            tick_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad_q <= 1'b0;
            armed_q   <= 1'b0;
            busy_q    <= 1'b0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            hist_q    <= hist_d;
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_bad_q <= par_bad_d;
            armed_q   <= armed_d;
            busy_q    <= busy_d;
            p_data_q  <= p_data_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
        end
    end

    assign P_data     = p_data_q;
    assign DATA_VALID = dv_q;
    assign PAR_ERR    = perr_q;
    assign STP_ERR    = serr_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: directed table, corner sequences,
// and randomized frames checked against a frame-level outcome model.
module tb_uart_rx;

    localparam int BIT = 16;
    localparam int K_DV = 0;
    localparam int K_PERR = 1;
    localparam int K_SERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic       pbit;
        logic       stop;
        int         exp_kind;
        logic [7:0] exp_pdata;
    } vec_t;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_data;
    logic       DATA_VALID, PAR_ERR, STP_ERR, Busy;

    int         vectors = 0;
    int         miscompares = 0;
    ev_t        ev_q[$];
    int         busy_total = 0;
    logic [7:0] pdata_prev = 8'h00;
    logic       rst_at_edge = 1'b1;
    logic [7:0] model_pdata = 8'h00;

    uart_rx #(
        .CLK_freq (16_000_000),
        .BAUD_RATE(1_000_000)
    ) dut (
        .CLK       (clk),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_data    (P_data),
        .DATA_VALID(DATA_VALID),
        .PAR_ERR   (PAR_ERR),
        .STP_ERR   (STP_ERR),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rst_at_edge <= RST;

    // Collect output pulses and watch that P_data only moves with DATA_VALID
    always @(negedge clk) begin
        if (DATA_VALID) ev_q.push_back('{K_DV, P_data});
        if (PAR_ERR)    ev_q.push_back('{K_PERR, P_data});
        if (STP_ERR)    ev_q.push_back('{K_SERR, P_data});
        if (Busy) busy_total++;
        if (!rst_at_edge && P_data != pdata_prev) check("pdata_only_with_dv", int'(DATA_VALID), 1);
        pdata_prev = P_data;
    end

    // Frame-level model: parity counts ones over data plus parity bit
    function automatic int ref_kind(input logic [7:0] d, input logic pe, input logic pt,
                                    input logic pb, input logic st);
        int ones;
        ones = $countones(d) + ((pe && pb) ? 1 : 0);
        if (!st) return K_SERR;
        if (pe && ((ones % 2) != int'(pt))) return K_PERR;
        return K_DV;
    endfunction

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par, input logic pbit,
                              input logic stop, input logic scramble);
        drive_bit(1'b0);
        if (scramble) begin
            PAR_EN  = 1'($urandom_range(0, 1));
            PAR_TYP = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (with_par) drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic expect_frame(input string name, input int kind, input logic [7:0] d,
                                input logic [7:0] exp_pdata);
        check({name, "_events"}, ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            check({name, "_kind"}, ev_q[0].kind, kind);
            if (kind == K_DV) check({name, "_data"}, int'(ev_q[0].data), int'(d));
        end
        ev_q.delete();
        check({name, "_pdata"}, int'(P_data), int'(exp_pdata));
    endtask

    initial begin
        vec_t       tbl[8];
        int         b0;
        int         kind;
        logic [7:0] d;
        logic       pe, pt, pb, st;
        logic [9:0] fr;
        logic       lvl;
        logic [7:0] b2b[3];

        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, K_DV,   8'hA5};
        tbl[1] = '{8'h37, 1'b1, 1'b0, 1'b1, 1'b1, K_DV,   8'h37};
        tbl[2] = '{8'h37, 1'b1, 1'b0, 1'b0, 1'b1, K_PERR, 8'h37};
        tbl[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, K_DV,   8'h00};
        tbl[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, K_DV,   8'hFF};
        tbl[5] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1, K_PERR, 8'hFF};
        tbl[6] = '{8'hC6, 1'b1, 1'b1, 1'b0, 1'b1, K_PERR, 8'hFF};
        tbl[7] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, K_SERR, 8'hFF};

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        check("rst_pdata", int'(P_data), 0);
        check("rst_dv", int'(DATA_VALID), 0);
        check("rst_perr", int'(PAR_ERR), 0);
        check("rst_serr", int'(STP_ERR), 0);
        check("rst_busy", int'(Busy), 0);
        RST = 1'b0;
        idle(10);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            PAR_EN  = tbl[i].par_en;
            PAR_TYP = tbl[i].par_typ;
            b0 = busy_total;
            send_frame(tbl[i].data, tbl[i].par_en, tbl[i].pbit, tbl[i].stop, 1'b0);
            if (i == 0) check("busy_len_in_range", int'(busy_total - b0 >= 144 && busy_total - b0 <= 160), 1);
            expect_frame($sformatf("tbl%0d", i), tbl[i].exp_kind, tbl[i].data, tbl[i].exp_pdata);
            idle(20);
        end
        model_pdata = 8'hFF;

        // Stop error followed by a break: one STP_ERR, then silence until release
        PAR_EN = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        RX_IN = 1'b0;
        repeat (3 * 10 * BIT) @(negedge clk);
        expect_frame("break", K_SERR, 8'h5A, model_pdata);
        idle(20);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        model_pdata = 8'h81;
        expect_frame("after_break", K_DV, 8'h81, model_pdata);
        idle(20);

        // Short low glitch on an idle line
        b0 = busy_total;
        RX_IN = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("glitch_events", ev_q.size(), 0);
        check("glitch_busy_brief", int'(busy_total - b0 > 0 && busy_total - b0 < BIT), 1);
        check("glitch_pdata", int'(P_data), int'(model_pdata));
        ev_q.delete();

        // Back-to-back frames with no idle gap
        b2b[0] = 8'h01; b2b[1] = 8'hFE; b2b[2] = 8'h7F;
        for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b0, 1'b0, 1'b1, 1'b0);
        check("b2b_events", ev_q.size(), 3);
        for (int i = 0; i < 3 && i < ev_q.size(); i++) begin
            check($sformatf("b2b%0d_kind", i), ev_q[i].kind, K_DV);
            check($sformatf("b2b%0d_data", i), int'(ev_q[i].data), int'(b2b[i]));
        end
        ev_q.delete();
        model_pdata = 8'h7F;
        check("b2b_pdata", int'(P_data), int'(model_pdata));
        idle(20);

        // One-cycle inverted level at the middle of data bit 2 of 0x55
        fr = {1'b1, 8'h55, 1'b0};
        for (int c = 0; c < 10 * BIT; c++) begin
            lvl = fr[c / BIT];
            if (c == 3 * BIT + 8) lvl = ~lvl;
            RX_IN = lvl;
            @(negedge clk);
        end
`ifdef UART_RX_MAJORITY_EN
        model_pdata = 8'h55;
`else
        model_pdata = 8'h51;
`endif
        expect_frame("sample_glitch", K_DV, model_pdata, model_pdata);
        idle(20);

        // Reset in the middle of bit 4 of 0xC3
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d8(8'hC3, i));
        RX_IN = 1'b0;
        repeat (8) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        RX_IN = 1'b1;
        check("midrst_pdata", int'(P_data), 0);
        check("midrst_dv", int'(DATA_VALID), 0);
        check("midrst_perr", int'(PAR_ERR), 0);
        check("midrst_serr", int'(STP_ERR), 0);
        check("midrst_busy", int'(Busy), 0);
        idle(30);
        check("midrst_no_pulse", ev_q.size(), 0);
        ev_q.delete();
        model_pdata = 8'h00;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        model_pdata = 8'h3C;
        expect_frame("after_rst", K_DV, 8'h3C, model_pdata);
        idle(10);

        // Randomized frames; parity controls are scrambled after the start bit
        for (int n = 0; n < 40; n++) begin
            d  = 8'($urandom);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            pb = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 7) != 0);
            PAR_EN  = pe;
            PAR_TYP = pt;
            send_frame(d, pe, pb, st, 1'b1);
            kind = ref_kind(d, pe, pt, pb, st);
            if (kind == K_DV) model_pdata = d;
            expect_frame($sformatf("rnd%0d", n), kind, d, model_pdata);
            if (!st || $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 6)));
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    function automatic logic d8(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
